// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control sequencer: state enum,
// MIPS opcode/funct constants, ALU op codes and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RST      = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WR   = 4'd7,
    ST_WB_R     = 4'd8,
    ST_WB_I     = 4'd9,
    ST_WB_MEM   = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12,
    ST_TRAP     = 4'd13
  } state_e;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-type funct codes the sequencer cares about (IR[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  // REGIMM rt selectors
  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  // alu_op codes
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_XOR   = 3'd4;
  localparam logic [2:0] ALU_SLT   = 3'd5;
  localparam logic [2:0] ALU_SLTU  = 3'd6;
  localparam logic [2:0] ALU_FUNCT = 3'd7;

  // pc_src
  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REG_A  = 2'd3;

  // alu_src_b
  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  // reg_dst
  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  // mem_to_reg
  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  // mem_size
  localparam logic [1:0] MSIZE_WORD = 2'd0;
  localparam logic [1:0] MSIZE_HALF = 2'd1;
  localparam logic [1:0] MSIZE_BYTE = 2'd2;

  function automatic logic is_load(input logic [5:0] o);
    return o inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input logic [5:0] o);
    return o inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_imm_alu(input logic [5:0] o);
    return o inside {OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
  endfunction

  function automatic logic [1:0] mem_size_of(input logic [5:0] o);
    case (o)
      OP_LB, OP_LBU, OP_SB: return MSIZE_BYTE;
      OP_LH, OP_LHU, OP_SH: return MSIZE_HALF;
      default:              return MSIZE_WORD;
    endcase
  endfunction

  // ALU operation for the immediate-arithmetic group
  function automatic logic [2:0] imm_alu_op(input logic [5:0] o);
    case (o)
      OP_SLTI:  return ALU_SLT;
      OP_SLTIU: return ALU_SLTU;
      OP_ANDI:  return ALU_AND;
      OP_ORI:   return ALU_OR;
      OP_XORI:  return ALU_XOR;
      default:  return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-wait watchdog: counts consecutive not-ready cycles spent in a
// waiting state and flags expiry on the cycle the count reaches WAIT_MAX.
module mc_wait_timer #(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_en,
  input  logic mem_ready,
  output logic expired
);

  localparam int unsigned CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [CW-1:0] LIMIT = CW'((WAIT_MAX == 0) ? 0 : WAIT_MAX - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count stalled cycles; a completed request or leaving the wait state restarts the count
  always_comb begin
    // NOTE: assign every always_comb output a default first so no path leaves it unassigned (no latch).
    cnt_d = '0;
    if (wait_en && !mem_ready) cnt_d = cnt_q + 1'b1;
  end

  // Expiry is this cycle being the WAIT_MAX-th stall; a ready in the same cycle wins
  assign expired = (WAIT_MAX != 0) && wait_en && !mem_ready && (cnt_q == LIMIT);

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control sequencer: walks each instruction through
// fetch/decode/execute/memory/writeback and decodes datapath controls
// from the current state. Illegal opcodes and memory timeouts trap.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic       alu_zero,
  input  logic       rs_zero,
  input  logic       rs_neg,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic [1:0] mem_size,
  output logic       mem_sign,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       ext_sign,
  output logic       shamt_sel,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       illegal_op,
  output logic       timeout,
  output logic [3:0] state
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   timeout_q, timeout_d;
  logic   waiting, expired;
  logic   branch_taken, regimm_bad;

  assign waiting = state_q inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR};

  mc_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .wait_en  (waiting),
    .mem_ready(mem_ready),
    .expired  (expired)
  );

  // Branch condition from opcode (and rt for REGIMM); unknown REGIMM rt is illegal
  always_comb begin
    branch_taken = 1'b0;
    regimm_bad   = 1'b0;
    case (op)
      OP_BEQ:  branch_taken = alu_zero;
      OP_BNE:  branch_taken = !alu_zero;
      OP_BLEZ: branch_taken = rs_neg | rs_zero;
      OP_BGTZ: branch_taken = !rs_neg & !rs_zero;
      OP_REGIMM: begin
        if      (rt == RT_BLTZ) branch_taken = rs_neg;
        else if (rt == RT_BGEZ) branch_taken = !rs_neg;
        else                    regimm_bad   = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state and sticky trap-cause logic
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_RST:   state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else if (expired) begin
          state_d   = ST_TRAP;
          timeout_d = 1'b1;
        end
      end
      ST_DECODE: begin
        if (op == OP_RTYPE) begin
          state_d = (funct == FN_JR || funct == FN_JALR) ? ST_JUMP : ST_EXEC_R;
        end else if (is_imm_alu(op)) begin
          state_d = ST_EXEC_I;
        end else if (is_load(op) || is_store(op)) begin
          state_d = ST_MEM_ADDR;
        end else if (op inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM}) begin
          state_d = ST_BRANCH;
        end else if (op == OP_J || op == OP_JAL) begin
          state_d = ST_JUMP;
        end else begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end
      end
      ST_EXEC_R:   state_d = ST_WB_R;
      ST_WB_R:     state_d = ST_FETCH;
      ST_EXEC_I:   state_d = ST_WB_I;
      ST_WB_I:     state_d = ST_FETCH;
      ST_MEM_ADDR: state_d = is_load(op) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD, ST_MEM_WR: begin
        if (mem_ready) begin
          state_d = (state_q == ST_MEM_RD) ? ST_WB_MEM : ST_FETCH;
        end else if (expired) begin
          state_d   = ST_TRAP;
          timeout_d = 1'b1;
        end
      end
      ST_WB_MEM: state_d = ST_FETCH;
      ST_BRANCH: begin
        if (regimm_bad) begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_JUMP: state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_RST;
    endcase
  end

  // State and trap-flag registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RST;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Moore decode of datapath controls; FETCH IR/PC writes and BRANCH pc_write gate on inputs
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_size   = MSIZE_WORD;
    mem_sign   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALU_ADD;
    ext_sign   = 1'b0;
    shamt_sel  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = DST_RT;
    mem_to_reg = WB_ALUOUT;
    case (state_q)
      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        ext_sign  = 1'b1;
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        shamt_sel = funct inside {FN_SLL, FN_SRL, FN_SRA};
      end
      ST_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = DST_RD;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = imm_alu_op(op);
        ext_sign  = op inside {OP_ADDIU, OP_SLTI, OP_SLTIU};
      end
      ST_WB_I: reg_write = 1'b1;
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_sign  = 1'b1;
      end
      ST_MEM_RD: begin
        mem_req  = 1'b1;
        mem_size = mem_size_of(op);
        mem_sign = (op == OP_LB) || (op == OP_LH);
      end
      ST_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_size = mem_size_of(op);
      end
      ST_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = WB_MDR;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_write  = branch_taken;
      end
      ST_JUMP: begin
        pc_write = 1'b1;
        if (op == OP_RTYPE) begin
          pc_src = PC_REG_A;
          if (funct == FN_JALR) begin
            reg_write  = 1'b1;
            reg_dst    = DST_RD;
            mem_to_reg = WB_PC;
          end
        end else begin
          pc_src = PC_JUMP;
          if (op == OP_JAL) begin
            reg_write  = 1'b1;
            reg_dst    = DST_RA;
            mem_to_reg = WB_PC;
          end
        end
      end
      default: ;
    endcase
  end

  assign illegal_op = illegal_q;
  assign timeout    = timeout_q;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: each driven cycle pushes the expected
// control word (with a care mask) and a negedge monitor pops and compares.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic [1:0] mem_size;
    logic       mem_sign;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       ext_sign;
    logic       shamt_sel;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       illegal_op;
    logic       timeout;
    logic [3:0] state;
  } ctl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic [4:0] rt = '0;
  logic alu_zero = 1'b0, rs_zero = 1'b0, rs_neg = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_we, mem_sign, ir_write, pc_write, alu_src_a;
  logic ext_sign, shamt_sel, reg_write, illegal_op, timeout;
  logic [1:0] mem_size, pc_src, alu_src_b, reg_dst, mem_to_reg;
  logic [2:0] alu_op;
  logic [3:0] state;

  logic rst_drive = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  ctl_t  val_q[$];
  ctl_t  care_q[$];
  string tag_q[$];
  ctl_t  obs;

  always #5 clk = ~clk;

  mc_ctrl #(.WAIT_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .rt(rt),
    .alu_zero(alu_zero), .rs_zero(rs_zero), .rs_neg(rs_neg), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_sign(mem_sign),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .ext_sign(ext_sign), .shamt_sel(shamt_sel), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal_op(illegal_op), .timeout(timeout), .state(state)
  );

  assign obs = {mem_req, mem_we, mem_size, mem_sign, ir_write, pc_write, pc_src,
                alu_src_a, alu_src_b, alu_op, ext_sign, shamt_sel, reg_write,
                reg_dst, mem_to_reg, illegal_op, timeout, state};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: one expectation per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (tag_q.size() != 0) begin
      string t;
      ctl_t v, c;
      logic [27:0] g, e;
      t = tag_q.pop_front();
      v = val_q.pop_front();
      c = care_q.pop_front();
      g = obs & c;
      e = v & c;
      check(t, 32'(g), 32'(e));
    end
  end

  function automatic ctl_t blank(input state_e s);
    ctl_t v;
    v = '0;
    v.state = s;
    return v;
  endfunction

  // All fields checked except ALU operand/op selects, which only some states define
  function automatic ctl_t care_std();
    ctl_t c;
    c = '1;
    c.alu_src_a = '0;
    c.alu_src_b = '0;
    c.alu_op    = '0;
    c.ext_sign  = '0;
    return c;
  endfunction

  task automatic drive(input logic rdy);
    @(posedge clk);
    #1;
    rst_n     = rst_drive;
    mem_ready = rdy;
  endtask

  task automatic push(input string tag, input ctl_t v, input ctl_t c);
    tag_q.push_back(tag);
    val_q.push_back(v);
    care_q.push_back(c);
  endtask

  task automatic t_rst(input string tag);
    drive(1'b1);
    push(tag, blank(ST_RST), '1);
  endtask

  task automatic t_fetch(input string tag, input logic rdy, input logic [5:0] op_v,
                         input logic [5:0] fn_v, input logic [4:0] rt_v);
    ctl_t v, c;
    drive(rdy);
    op = op_v; funct = fn_v; rt = rt_v;
    v = blank(ST_FETCH); c = care_std();
    v.mem_req = 1'b1; v.ir_write = rdy; v.pc_write = rdy; v.pc_src = PC_ALU;
    v.alu_src_a = 1'b0; v.alu_src_b = SRCB_FOUR; v.alu_op = ALU_ADD;
    c.alu_src_a = '1; c.alu_src_b = '1; c.alu_op = '1;
    push(tag, v, c);
  endtask

  task automatic t_decode(input string tag);
    ctl_t v, c;
    drive(1'b1);
    v = blank(ST_DECODE); c = care_std();
    v.alu_src_a = 1'b0; v.alu_src_b = SRCB_IMM_SH2; v.alu_op = ALU_ADD;
    c.alu_src_a = '1; c.alu_src_b = '1; c.alu_op = '1;
    push(tag, v, c);
  endtask

  task automatic t_exec_r(input string tag, input logic sh);
    ctl_t v, c;
    drive(1'b1);
    v = blank(ST_EXEC_R); c = care_std();
    v.alu_op = ALU_FUNCT; v.shamt_sel = sh; c.alu_op = '1;
    push(tag, v, c);
  endtask

  task automatic t_exec_i(input string tag, input logic sext);
    ctl_t v, c;
    drive(1'b1);
    v = blank(ST_EXEC_I); c = care_std();
    v.alu_src_b = SRCB_IMM; v.ext_sign = sext; c.alu_src_b = '1; c.ext_sign = '1;
    push(tag, v, c);
  endtask

  task automatic t_wb(input string tag, input state_e s, input logic [1:0] dst, input logic [1:0] m2r);
    ctl_t v;
    drive(1'b1);
    v = blank(s);
    v.reg_write = 1'b1; v.reg_dst = dst; v.mem_to_reg = m2r;
    push(tag, v, care_std());
  endtask

  task automatic t_mem_addr(input string tag);
    ctl_t v, c;
    drive(1'b1);
    v = blank(ST_MEM_ADDR); c = care_std();
    v.alu_src_a = 1'b1; v.alu_src_b = SRCB_IMM; v.alu_op = ALU_ADD; v.ext_sign = 1'b1;
    c.alu_src_a = '1; c.alu_src_b = '1; c.alu_op = '1; c.ext_sign = '1;
    push(tag, v, c);
  endtask

  task automatic t_mem(input string tag, input state_e s, input logic rdy,
                       input logic [1:0] sz, input logic sgn);
    ctl_t v;
    drive(rdy);
    v = blank(s);
    v.mem_req = 1'b1; v.mem_we = (s == ST_MEM_WR); v.mem_size = sz; v.mem_sign = sgn;
    push(tag, v, care_std());
  endtask

  task automatic t_branch(input string tag, input logic z, input logic n,
                          input logic rz, input logic taken);
    ctl_t v;
    drive(1'b1);
    alu_zero = z; rs_neg = n; rs_zero = rz;
    v = blank(ST_BRANCH);
    v.pc_src = PC_ALUOUT; v.pc_write = taken;
    push(tag, v, care_std());
  endtask

  task automatic t_jump(input string tag, input logic [1:0] src, input logic wr, input logic [1:0] dst);
    ctl_t v;
    drive(1'b1);
    v = blank(ST_JUMP);
    v.pc_write = 1'b1; v.pc_src = src; v.reg_write = wr;
    v.reg_dst = dst; v.mem_to_reg = wr ? WB_PC : WB_ALUOUT;
    push(tag, v, care_std());
  endtask

  task automatic t_trap(input string tag, input logic ill, input logic tmo, input logic rdy);
    ctl_t v;
    drive(rdy);
    v = blank(ST_TRAP);
    v.illegal_op = ill; v.timeout = tmo;
    push(tag, v, '1);
  endtask

  initial begin
    repeat (3) @(posedge clk);

    // Reset release: RST with all outputs low, then FETCH
    rst_drive = 1'b1;
    t_rst("rst_state");

    // ADDIU: 4 cycles
    t_fetch("addiu_fetch", 1'b1, OP_ADDIU, 6'h00, 5'd0);
    t_decode("addiu_decode");
    t_exec_i("addiu_exec", 1'b1);
    t_wb("addiu_wb", ST_WB_I, DST_RT, WB_ALUOUT);

    // LB with 3 wait cycles: 8 cycles
    t_fetch("lb_fetch", 1'b1, OP_LB, 6'h00, 5'd0);
    t_decode("lb_decode");
    t_mem_addr("lb_addr");
    for (int i = 0; i < 3; i++) t_mem("lb_wait", ST_MEM_RD, 1'b0, MSIZE_BYTE, 1'b1);
    t_mem("lb_ready", ST_MEM_RD, 1'b1, MSIZE_BYTE, 1'b1);
    t_wb("lb_wb", ST_WB_MEM, DST_RT, WB_MDR);

    // LHU: unsigned half load
    t_fetch("lhu_fetch", 1'b1, OP_LHU, 6'h00, 5'd0);
    t_decode("lhu_decode");
    t_mem_addr("lhu_addr");
    t_mem("lhu_rd", ST_MEM_RD, 1'b1, MSIZE_HALF, 1'b0);
    t_wb("lhu_wb", ST_WB_MEM, DST_RT, WB_MDR);

    // SW: 4 cycles
    t_fetch("sw_fetch", 1'b1, OP_SW, 6'h00, 5'd0);
    t_decode("sw_decode");
    t_mem_addr("sw_addr");
    t_mem("sw_wr", ST_MEM_WR, 1'b1, MSIZE_WORD, 1'b0);

    // R-type ADD; fetch stalls 3 cycles and ready arrives when the watchdog would hit
    for (int i = 0; i < 3; i++) t_fetch("add_fetch_wait", 1'b0, OP_RTYPE, 6'h20, 5'd0);
    t_fetch("add_fetch_ready_wins", 1'b1, OP_RTYPE, 6'h20, 5'd0);
    t_decode("add_decode");
    t_exec_r("add_exec", 1'b0);
    t_wb("add_wb", ST_WB_R, DST_RD, WB_ALUOUT);

    // SLL uses shamt
    t_fetch("sll_fetch", 1'b1, OP_RTYPE, FN_SLL, 5'd0);
    t_decode("sll_decode");
    t_exec_r("sll_exec", 1'b1);
    t_wb("sll_wb", ST_WB_R, DST_RD, WB_ALUOUT);

    // ORI zero-extends
    t_fetch("ori_fetch", 1'b1, OP_ORI, 6'h00, 5'd0);
    t_decode("ori_decode");
    t_exec_i("ori_exec", 1'b0);
    t_wb("ori_wb", ST_WB_I, DST_RT, WB_ALUOUT);

    // BGEZ taken / not taken
    t_fetch("bgez_fetch", 1'b1, OP_REGIMM, 6'h00, RT_BGEZ);
    t_decode("bgez_decode");
    t_branch("bgez_taken", 1'b0, 1'b0, 1'b0, 1'b1);
    t_fetch("bgez2_fetch", 1'b1, OP_REGIMM, 6'h00, RT_BGEZ);
    t_decode("bgez2_decode");
    t_branch("bgez_not_taken", 1'b0, 1'b1, 1'b0, 1'b0);

    // BNE with alu_zero set: not taken; BGTZ with rs_zero: not taken
    t_fetch("bne_fetch", 1'b1, OP_BNE, 6'h00, 5'd0);
    t_decode("bne_decode");
    t_branch("bne_not_taken", 1'b1, 1'b0, 1'b0, 1'b0);
    t_fetch("bgtz_fetch", 1'b1, OP_BGTZ, 6'h00, 5'd0);
    t_decode("bgtz_decode");
    t_branch("bgtz_zero", 1'b0, 1'b0, 1'b1, 1'b0);

    // JAL, then JR
    t_fetch("jal_fetch", 1'b1, OP_JAL, 6'h00, 5'd0);
    t_decode("jal_decode");
    t_jump("jal_jump", PC_JUMP, 1'b1, DST_RA);
    t_fetch("jr_fetch", 1'b1, OP_RTYPE, FN_JR, 5'd0);
    t_decode("jr_decode");
    t_jump("jr_jump", PC_REG_A, 1'b0, DST_RT);
    t_fetch("jalr_fetch", 1'b1, OP_RTYPE, FN_JALR, 5'd0);
    t_decode("jalr_decode");
    t_jump("jalr_jump", PC_REG_A, 1'b1, DST_RD);

    // REGIMM with unsupported rt traps from BRANCH
    t_fetch("regimm_bad_fetch", 1'b1, OP_REGIMM, 6'h00, 5'd5);
    t_decode("regimm_bad_decode");
    t_branch("regimm_bad_branch", 1'b0, 1'b1, 1'b0, 1'b0);
    t_trap("regimm_bad_trap", 1'b1, 1'b0, 1'b0);
    rst_drive = 1'b0;
    t_trap("trap_during_rst", 1'b1, 1'b0, 1'b1);
    rst_drive = 1'b1;
    t_rst("rst_clears_illegal");

    // Watchdog: 4 stalled FETCH cycles then TRAP with timeout; ready is ignored in TRAP
    for (int i = 0; i < 4; i++) t_fetch("wdog_fetch", 1'b0, OP_RTYPE, 6'h20, 5'd0);
    t_trap("wdog_trap", 1'b0, 1'b1, 1'b0);
    t_trap("wdog_trap_hold", 1'b0, 1'b1, 1'b1);
    rst_drive = 1'b0;
    t_trap("wdog_trap_in_rst", 1'b0, 1'b1, 1'b0);
    rst_drive = 1'b1;
    t_rst("rst_clears_timeout");

    // Illegal opcode 0x3F
    t_fetch("ill_fetch", 1'b1, 6'h3F, 6'h00, 5'd0);
    t_decode("ill_decode");
    t_trap("ill_trap", 1'b1, 1'b0, 1'b0);

    // Reset mid-wait: counter must restart so 3 more stalls do not trap
    rst_drive = 1'b0;
    t_trap("ill_trap_in_rst", 1'b1, 1'b0, 1'b0);
    rst_drive = 1'b1;
    t_rst("rst_after_illegal");
    for (int i = 0; i < 2; i++) t_fetch("midwait_fetch", 1'b0, OP_ADDIU, 6'h00, 5'd0);
    rst_drive = 1'b0;
    t_fetch("midwait_rst", 1'b0, OP_ADDIU, 6'h00, 5'd0);
    rst_drive = 1'b1;
    t_rst("midwait_rst_state");
    for (int i = 0; i < 3; i++) t_fetch("post_rst_wait", 1'b0, OP_ADDIU, 6'h00, 5'd0);
    t_fetch("post_rst_ready", 1'b1, OP_ADDIU, 6'h00, 5'd0);
    t_decode("post_rst_decode");

    repeat (2) @(negedge clk);
    check("scoreboard_drain", 32'(tag_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle control sequencer for the MIPS-subset core, replacing the single-cycle control decoder. A state machine walks each instruction through fetch, decode, execute, memory and writeback, and produces per-state datapath controls. It handshakes with a variable-latency memory port and traps on illegal opcodes or memory timeouts. It sits between the instruction register and the shared multicycle datapath (PC, IR, A/B, ALUOut, MDR).

## Interface
- `WAIT_MAX`, default 16: memory-wait watchdog limit in cycles; 0 disables it.
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `op`  in  6  IR[31:26]; stable from DECODE onward
- `funct`  in  6  IR[5:0]
- `rt`  in  5  IR[20:16]; selects BLTZ/BGEZ
- `alu_zero`  in  1  ALU result == 0
- `rs_zero`, `rs_neg`  in  1 each  rs == 0, rs[31]
- `mem_ready`  in  1  memory completes the current request
- `mem_req`, `mem_we`  out  1 each  memory request, write enable
- `mem_size`  out  2  0 word, 1 half, 2 byte
- `mem_sign`  out  1  sign-extend the load
- `ir_write`, `pc_write`  out  1 each  latch IR, write PC
- `pc_src`  out  2  0 ALU result, 1 ALUOut, 2 jump target, 3 register A
- `alu_src_a`  out  1  0 PC, 1 A
- `alu_src_b`  out  2  0 B, 1 const 4, 2 ext imm, 3 ext imm<<2
- `alu_op`  out  3  package code
- `ext_sign`, `shamt_sel`  out  1 each  immediate sign-extend; shift uses shamt
- `reg_write`  out  1  register-file write
- `reg_dst`  out  2  0 rt, 1 rd, 2 $31
- `mem_to_reg`  out  2  0 ALUOut, 1 MDR, 2 PC
- `illegal_op`, `timeout`  out  1 each  sticky trap causes
- `state`  out  4  current state, for debug

## Operation
- States: RST, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, TRAP.
- RST → FETCH unconditionally. All outputs are 0 in RST.
- FETCH
  - `mem_req`=1, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=ADD.
  - In the cycle `mem_ready`=1: `ir_write`=`pc_write`=1 (`pc_src`=0), then go to DECODE.
- DECODE: ALUOut ← PC+(imm<<2). Dispatch:
  - RTYPE JR/JALR → JUMP
  - other RTYPE → EXEC_R
  - ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI → EXEC_I
  - loads/stores → MEM_ADDR
  - BEQ/BNE/BLEZ/BGTZ/REGIMM → BRANCH
  - J/JAL → JUMP
  - anything else → TRAP with `illegal_op`=1
- EXEC_R: `alu_op`=FUNCT; `shamt_sel`=1 for SLL/SRL/SRA. Then WB_R.
- WB_R: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Then FETCH.
- EXEC_I: `alu_src_b`=2; `ext_sign`=1 for ADDIU/SLTI/SLTIU. Then WB_I.
- WB_I: `reg_write`=1, `reg_dst`=0. Then FETCH.
- MEM_ADDR: ADD of A and the sign-extended immediate. Then MEM_RD for loads, MEM_WR for stores.
- MEM_RD / MEM_WR
  - Hold `mem_req` (with `mem_we`=1 in MEM_WR), `mem_size` and `mem_sign` (1 for LB/LH only) until `mem_ready`.
  - MEM_RD then goes to WB_MEM (`reg_write`=1, `mem_to_reg`=1), then FETCH.
  - MEM_WR goes to FETCH.
- BRANCH: `pc_src`=1. `pc_write` is 1 if the condition holds:
  - BEQ: `alu_zero`; BNE: !`alu_zero`
  - BLEZ: `rs_neg`|`rs_zero`; BGTZ: !`rs_neg`&!`rs_zero`
  - BLTZ (rt=0): `rs_neg`; BGEZ (rt=1): !`rs_neg`
  - REGIMM with any other rt → TRAP with `illegal_op`.
  - Then FETCH.
- JUMP: `pc_write`=1.
  - J/JAL use `pc_src`=2; JR/JALR use `pc_src`=3.
  - JAL/JALR also write: `reg_write`=1, `mem_to_reg`=2, `reg_dst`=2 (JAL) or 1 (JALR).
  - Then FETCH.
- Watchdog
  - Counts cycles in a waiting state while `mem_ready`=0. It clears when the state is left.
  - When the count reaches `WAIT_MAX`: go to TRAP with `timeout`=1, and drop `mem_req`.
- TRAP: all controls 0; stays there until reset. `illegal_op` and `timeout` hold.

## Timing
- Controls are a Moore decode of the state. The exception is FETCH `ir_write`/`pc_write`, which are gated by `mem_ready`.
- Cycle counts with immediate `mem_ready`: R/I-type 4, load 5, store 4, branch 3, jump 3. Each wait cycle adds 1.
- Reset takes effect at any edge, in any state, including mid-wait. The next state is RST and all outputs are 0 the following cycle. The trap flags and the counter clear.
- `mem_ready` seen outside a waiting state is ignored.
- If `mem_ready` arrives in the same cycle the watchdog hits its limit, ready wins.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state enum
  - opcode and funct constants
  - `alu_op` codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, FUNCT 7
  - `pc_src`, `alu_src_b`, `reg_dst` and `mem_to_reg` encodings
- One sub-module, `mc_wait_timer` (parametrised by `WAIT_MAX`), implements the watchdog counter.

## Test plan
- Reset: with `rst_n`=0 then 1, outputs are 0 in RST; the next cycle has `state`=FETCH and `mem_req`=1.
- ADDIU (op 0x09) with `mem_ready` always 1: FETCH→DECODE→EXEC_I→WB_I; WB_I has `reg_write`=1, `reg_dst`=0; 4 cycles total.
- LB (op 0x20) with 3 wait cycles in MEM_RD: `mem_size`=2 and `mem_sign`=1 are held for 4 cycles; WB_MEM follows; 8 cycles total.
- BGEZ (op 0x01, rt=1): with `rs_neg`=0, `pc_write`=1 and `pc_src`=1; with `rs_neg`=1, `pc_write`=0.
- JAL (op 0x03): JUMP has `pc_src`=2, `reg_dst`=2, `mem_to_reg`=2 and `reg_write`=1.
- With `WAIT_MAX`=4 and `mem_ready` stuck at 0 in FETCH, TRAP is entered at count 4 with `timeout`=1. Op 0x3F goes to TRAP with `illegal_op`=1. Reset clears both.
